// File: rtl/wb_stage_if.sv
// Register-file write port and WB->ID forwarding bus driven by wb_stage.
// master: the write-back stage; slave: register file / decode bypass.
interface wb_stage_if #(
    parameter int unsigned BITS_SIZE = 32,
    parameter int unsigned BITS_REGS = 5
);
    logic                 o_wr_enable;
    logic [BITS_REGS-1:0] o_wr_addr;
    logic [BITS_SIZE-1:0] o_wr_data;
    logic                 o_fwd_valid;
    logic [BITS_REGS-1:0] o_fwd_addr;
    logic [BITS_SIZE-1:0] o_fwd_data;

    modport master (
        output o_wr_enable, o_wr_addr, o_wr_data,
        output o_fwd_valid, o_fwd_addr, o_fwd_data
    );

    modport slave (
        input o_wr_enable, o_wr_addr, o_wr_data,
        input o_fwd_valid, o_fwd_addr, o_fwd_data
    );
endinterface

// File: rtl/wb_stage.sv
// Write-back stage: load filter, result mux, register-file write, forwarding,
// retired counter and sticky halt. Optional trace port under `WB_TRACE_EN`.
module wb_stage #(
    parameter int unsigned BITS_SIZE = 32,
    parameter int unsigned BITS_REGS = 5,
    parameter int unsigned CNT_BITS  = 32
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_step,
    input  logic [BITS_SIZE-1:0] i_pc4,
    input  logic [BITS_SIZE-1:0] i_pc8,
    input  logic [BITS_SIZE-1:0] i_instruction,
    input  logic [BITS_SIZE-1:0] i_alu,
    input  logic [BITS_SIZE-1:0] i_dato_mem,
    input  logic [BITS_REGS-1:0] i_register_rd_dst,
    input  logic [BITS_SIZE-1:0] i_extension,
    input  logic                 i_jal,
    input  logic                 i_lui,
    input  logic                 i_mem_to_reg,
    input  logic                 i_register_write,
    input  logic                 i_zero_extend,
    input  logic                 i_halt,
    input  logic [1:0]           i_size_filterL,
    wb_stage_if.master           wb,
    output logic [CNT_BITS-1:0]  o_retired,
    output logic                 o_halted
`ifdef WB_TRACE_EN
    ,
    output logic                 o_trace_valid,
    output logic [BITS_SIZE-1:0] o_trace_pc,
    output logic [BITS_SIZE-1:0] o_trace_data
`endif
);

    typedef enum logic {
        ST_RUN,
        ST_HALTED
    } state_t;

    state_t state_q, state_d;

    logic [BITS_SIZE-1:0] load_val;
    logic [BITS_SIZE-1:0] result;
    logic                 wr_en;
    logic                 running;
    logic                 non_bubble;
    logic                 fill_b, fill_h;

    assign running    = (state_q == ST_RUN);
    assign non_bubble = (i_instruction != '0);

    // Upper extension bits are never consumed by lui.
`ifdef WB_TRACE_EN
    logic unused_bits;
    assign unused_bits = ^i_extension[BITS_SIZE-1:16];
`else
    logic unused_bits;
    assign unused_bits = ^{i_extension[BITS_SIZE-1:16], i_pc4};
`endif

    assign fill_b = ~i_zero_extend & i_dato_mem[7];
    assign fill_h = ~i_zero_extend & i_dato_mem[15];

    always_comb begin
        load_val = i_dato_mem;
        case (i_size_filterL)
            2'b00:   load_val = {{(BITS_SIZE-8){fill_b}}, i_dato_mem[7:0]};
            2'b01:   load_val = {{(BITS_SIZE-16){fill_h}}, i_dato_mem[15:0]};
            default: load_val = i_dato_mem;
        endcase
    end

    always_comb begin
        result = i_alu;
        if (i_jal)
            result = i_pc8;
        else if (i_lui)
            result = {i_extension[15:0], {(BITS_SIZE-16){1'b0}}};
        else if (i_mem_to_reg)
            result = load_val;
    end

    // The halt instruction itself never writes the register file.
    assign wr_en = i_step & i_register_write & (i_register_rd_dst != '0)
                 & running & ~i_halt & ~i_reset;

    assign wb.o_wr_enable = wr_en;
    assign wb.o_wr_addr   = i_register_rd_dst;
    assign wb.o_wr_data   = result;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:    if (i_step && i_halt) state_d = ST_HALTED;
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) state_q <= ST_RUN;
        else         state_q <= state_d;
    end

    assign o_halted = (state_q == ST_HALTED);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wb.o_fwd_valid <= 1'b0;
            wb.o_fwd_addr  <= '0;
            wb.o_fwd_data  <= '0;
        end else if (i_step) begin
            if (running) begin
                wb.o_fwd_valid <= wr_en;
                wb.o_fwd_addr  <= i_register_rd_dst;
                wb.o_fwd_data  <= result;
            end else begin
                wb.o_fwd_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            o_retired <= '0;
        else if (i_step && running && non_bubble && (o_retired != '1))
            o_retired <= o_retired + CNT_BITS'(1);
    end

`ifdef WB_TRACE_EN
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_trace_valid <= 1'b0;
            o_trace_pc    <= '0;
            o_trace_data  <= '0;
        end else begin
            o_trace_valid <= i_step & running & non_bubble;
            if (i_step && running && non_bubble) begin
                o_trace_pc   <= i_pc4 - BITS_SIZE'(4);
                o_trace_data <= result;
            end
        end
    end
`endif

endmodule
